imm_encoder: RTL and testbench

Inverse of the core's immediate decode path: accepts instruction fields plus a full 32-bit immediate and an `imm_type`, range-checks the immediate and packs it into a legal 32-bit RV32 instruction word. Results pass through a small output FIFO with valid/ready on both sides. It sits in the BIOS/self-test and trace-replay infrastructure, which synthesises instructions at run time. The `imm_type` encoding is identical to the decode side, so encode-then-decode round-trips exactly.

---
 rtl/imm_pkg.sv | 55 +++++
 rtl/sync_fifo.sv | 50 +++++
 rtl/imm_encoder.sv | 72 +++++++
 tb/tb_imm_encoder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared definitions for the RV32 immediate encoder: type codes, request and
// response records, and the pack / range-check functions.
package imm_pkg;

  localparam logic [2:0] IMM_I   = 3'd0;
  localparam logic [2:0] IMM_S   = 3'd1;
  localparam logic [2:0] IMM_B   = 3'd2;
  localparam logic [2:0] IMM_U   = 3'd3;
  localparam logic [2:0] IMM_J   = 3'd4;
  localparam logic [2:0] IMM_CSR = 3'd5;

  typedef struct packed {
    logic [2:0]  imm_type;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } imm_req_t;

  typedef struct packed {
    logic        err;
    logic [31:0] instr;
  } imm_rsp_t;

  // True when imm fits the immediate field of the given type.
  function automatic logic imm_legal(input logic [2:0] t, input logic [31:0] imm);
    case (t)
      IMM_I, IMM_S: return (imm[31:11] == '0) || (imm[31:11] == '1);
      IMM_B:        return ((imm[31:12] == '0) || (imm[31:12] == '1)) && !imm[0];
      IMM_U:        return imm[11:0] == '0;
      IMM_J:        return ((imm[31:20] == '0) || (imm[31:20] == '1)) && !imm[0];
      IMM_CSR:      return imm[31:5] == '0;
      default:      return 1'b0;
    endcase
  endfunction

  // Scatters the immediate into the instruction layout of its type.
  function automatic logic [31:0] imm_encode(input imm_req_t r);
    logic [31:0] i;
    i = r.imm;
    case (r.imm_type)
      IMM_I:   return {i[11:0], r.rs1, r.funct3, r.rd, r.opcode};
      IMM_S:   return {i[11:5], r.rs2, r.rs1, r.funct3, i[4:0], r.opcode};
      IMM_B:   return {i[12], i[10:5], r.rs2, r.rs1, r.funct3, i[4:1], i[11], r.opcode};
      IMM_U:   return {i[31:12], r.rd, r.opcode};
      IMM_J:   return {i[20], i[10:1], i[11], i[19:12], r.rd, r.opcode};
      IMM_CSR: return {r.funct7, r.rs2, i[4:0], r.funct3, r.rd, r.opcode};
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; DEPTH must be a power of two so pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic [CW-1:0]               count;
  logic                        do_wr, do_rd;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage, pointers and occupancy; reset discards all entries at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/imm_encoder.sv
// Packs instruction fields plus a full immediate into an RV32 word, flags
// out-of-range immediates, and queues {err, instr} in a small output FIFO.
module imm_encoder
  import imm_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       imm_type,
  input  logic [31:0]      imm,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  input  logic             err_clr,
  output logic [ERR_W-1:0] err_count
);
  imm_req_t req;
  imm_rsp_t wr_rsp, rd_rsp;
  logic     push, pop, full, empty;

  assign req = '{imm_type: imm_type, imm: imm, opcode: opcode, funct3: funct3,
                 funct7: funct7, rd: rd, rs1: rs1, rs2: rs2};

  // Combinational encode and range check feeding the FIFO write port.
  always_comb begin
    wr_rsp.err   = !imm_legal(imm_type, imm);
    wr_rsp.instr = wr_rsp.err ? 32'h0 : imm_encode(req);
  end

  // in_ready depends on FIFO occupancy only, never on out_ready.
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  // Idle outputs read as zero rather than a stale slot.
  assign out_instr = empty ? 32'h0 : rd_rsp.instr;
  assign out_err   = empty ? 1'b0  : rd_rsp.err;

  sync_fifo #(.WIDTH($bits(imm_rsp_t)), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (push),
    .wr_data(wr_rsp),
    .rd_en  (pop),
    .rd_data(rd_rsp),
    .full   (full),
    .empty  (empty)
  );

  // Saturating count of accepted bad requests; a clear coinciding with an
  // erroneous accept leaves that one counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_count <= '0;
    else if (err_clr)
      err_count <= (push && wr_rsp.err) ? ERR_W'(1) : '0;
    else if (push && wr_rsp.err && !(&err_count))
      err_count <= err_count + 1'b1;
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: spec vectors, hand-built corner
// sequences, then randomized traffic against an arithmetic reference model.
module tb_imm_encoder;
  localparam int DEPTH   = 2;
  localparam int ERR_W   = 4;
  localparam int ERR_MAX = 15;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, out_valid, out_ready, out_err, err_clr;
  logic [2:0]       imm_type, funct3;
  logic [31:0]      imm, out_instr;
  logic [6:0]       opcode, funct7;
  logic [4:0]       rd, rs1, rs2;
  logic [ERR_W-1:0] err_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] t; logic [31:0] imm; logic [6:0] op; logic [2:0] f3;
    logic [6:0] f7; logic [4:0] rd; logic [4:0] rs1; logic [4:0] rs2;
  } req_t;
  typedef struct { req_t r; logic [31:0] exp_instr; logic exp_err; } vec_t;

  imm_encoder #(.DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .imm_type(imm_type), .imm(imm), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_err(out_err),
    .err_clr(err_clr), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference: legality from numeric ranges, layout from shift/mask placement.
  function automatic logic [32:0] model(input req_t r);
    int          s;
    logic        ok;
    logic [31:0] w, u, base;
    s = $signed(r.imm);
    u = r.imm;
    base = 32'(r.op);
    case (r.t)
      3'd0, 3'd1: ok = (s >= -2048) && (s <= 2047);
      3'd2:       ok = (s >= -4096) && (s <= 4095) && ((s % 2) == 0);
      3'd3:       ok = (u % 4096) == 0;
      3'd4:       ok = (s >= -(1 << 20)) && (s < (1 << 20)) && ((s % 2) == 0);
      3'd5:       ok = u < 32;
      default:    ok = 1'b0;
    endcase
    case (r.t)
      3'd0: w = ((u & 32'hFFF) << 20) | (32'(r.rs1) << 15) | (32'(r.f3) << 12)
              | (32'(r.rd) << 7) | base;
      3'd1: w = (((u >> 5) & 32'h7F) << 25) | (32'(r.rs2) << 20) | (32'(r.rs1) << 15)
              | (32'(r.f3) << 12) | ((u & 32'h1F) << 7) | base;
      3'd2: w = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (32'(r.rs2) << 20)
              | (32'(r.rs1) << 15) | (32'(r.f3) << 12) | (((u >> 1) & 32'hF) << 8)
              | (((u >> 11) & 1) << 7) | base;
      3'd3: w = (u & 32'hFFFFF000) | (32'(r.rd) << 7) | base;
      3'd4: w = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21)
              | (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hFF) << 12)
              | (32'(r.rd) << 7) | base;
      3'd5: w = (32'(r.f7) << 25) | (32'(r.rs2) << 20) | ((u & 32'h1F) << 15)
              | (32'(r.f3) << 12) | (32'(r.rd) << 7) | base;
      default: w = 32'h0;
    endcase
    return {!ok, ok ? w : 32'h0};
  endfunction

  task automatic apply(input req_t r);
    imm_type = r.t; imm = r.imm; opcode = r.op; funct3 = r.f3;
    funct7 = r.f7; rd = r.rd; rs1 = r.rs1; rs2 = r.rs2;
  endtask

  function automatic req_t mk(input logic [2:0] t, input logic [31:0] v, input logic [6:0] op,
                              input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] d,
                              input logic [4:0] s1, input logic [4:0] s2);
    req_t r;
    r.t = t; r.imm = v; r.op = op; r.f3 = f3; r.f7 = f7; r.rd = d; r.rs1 = s1; r.rs2 = s2;
    return r;
  endfunction

  vec_t        vecs[$];
  logic [32:0] q[$];
  int          exp_cnt;
  req_t        ra, rb, rc, rr;
  logic [32:0] ma, mb, mc, mr;
  logic        acc, pp;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    apply(mk(3'd0, 32'h0, 7'h0, 3'h0, 7'h0, 5'h0, 5'h0, 5'h0));
    exp_cnt = 0;

    // Reset state while rst_n is held.
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Directed vectors, expected words worked out by hand.
    vecs.push_back('{mk(3'd0, 32'hFFFFFFFF, 7'h13, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0), 32'hFFF00093, 1'b0});
    vecs.push_back('{mk(3'd1, 32'h8,        7'h23, 3'd2, 7'h0, 5'd0, 5'd1, 5'd2), 32'h0020A423, 1'b0});
    vecs.push_back('{mk(3'd2, 32'hFFFFFFFC, 7'h63, 3'd0, 7'h0, 5'd0, 5'd0, 5'd0), 32'hFE000EE3, 1'b0});
    vecs.push_back('{mk(3'd4, 32'h800,      7'h6F, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0), 32'h001000EF, 1'b0});
    vecs.push_back('{mk(3'd0, 32'd2048,     7'h13, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0), 32'h0, 1'b1});
    vecs.push_back('{mk(3'd2, 32'd3,        7'h63, 3'd0, 7'h0, 5'd0, 5'd0, 5'd0), 32'h0, 1'b1});
    vecs.push_back('{mk(3'd7, 32'h0,        7'h13, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0), 32'h0, 1'b1});
    vecs.push_back('{mk(3'd0, 32'd2047,     7'h13, 3'd0, 7'h0, 5'd0, 5'd0, 5'd0), 32'h7FF00013, 1'b0});
    vecs.push_back('{mk(3'd0, 32'hFFFFF800, 7'h13, 3'd0, 7'h0, 5'd0, 5'd0, 5'd0), 32'h80000013, 1'b0});
    vecs.push_back('{mk(3'd3, 32'h12345000, 7'h37, 3'd0, 7'h0, 5'd5, 5'd0, 5'd0), 32'h123452B7, 1'b0});
    vecs.push_back('{mk(3'd5, 32'h1F,       7'h73, 3'd5, 7'h18, 5'd0, 5'd0, 5'd5), 32'h305FD073, 1'b0});
    vecs.push_back('{mk(3'd5, 32'd32,       7'h73, 3'd5, 7'h18, 5'd0, 5'd0, 5'd5), 32'h0, 1'b1});
    vecs.push_back('{mk(3'd3, 32'h800,      7'h37, 3'd0, 7'h0, 5'd5, 5'd0, 5'd0), 32'h0, 1'b1});
    vecs.push_back('{mk(3'd4, 32'h100000,   7'h6F, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0), 32'h0, 1'b1});

    // Back-to-back with out_ready high: each word visible one cycle after accept.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      apply(vecs[i].r); in_valid = 1'b1; out_ready = 1'b1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (vecs[i].exp_err && exp_cnt < ERR_MAX) exp_cnt++;
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_instr", i), out_instr, vecs[i].exp_instr);
      chk($sformatf("v%0d_err", i), 32'(out_err), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_err_count", i), 32'(err_count), 32'(exp_cnt));
    end

    // Clear coinciding with an erroneous accept counts that one; clear alone zeroes.
    @(negedge clk);
    apply(mk(3'd6, 32'h0, 7'h13, 3'd0, 7'h0, 5'd0, 5'd0, 5'd0));
    in_valid = 1'b1; err_clr = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0; err_clr = 1'b0;
    chk("clr_with_err", 32'(err_count), 32'd1);
    @(negedge clk); err_clr = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
    chk("clr_alone", 32'(err_count), 32'd0);
    repeat (2) @(posedge clk);
    #1 chk("drained", 32'(out_valid), 32'd0);

    // Backpressure: two accepts fill the FIFO, third request held.
    ra = mk(3'd0, 32'd1, 7'h13, 3'd0, 7'h0, 5'd1, 5'd2, 5'd0); ma = model(ra);
    rb = mk(3'd0, 32'd2, 7'h13, 3'd0, 7'h0, 5'd2, 5'd3, 5'd0); mb = model(rb);
    rc = mk(3'd0, 32'd3, 7'h13, 3'd0, 7'h0, 5'd3, 5'd4, 5'd0); mc = model(rc);
    @(negedge clk); out_ready = 1'b0; apply(ra); in_valid = 1'b1;
    @(posedge clk); #1 chk("bp_ready_after1", 32'(in_ready), 32'd1);
    @(negedge clk); apply(rb);
    @(posedge clk); #1 chk("bp_ready_after2", 32'(in_ready), 32'd0);
    @(negedge clk); apply(rc);
    @(posedge clk); #1;
    chk("bp_third_held", 32'(in_ready), 32'd0);
    chk("bp_head_stable", out_instr, ma[31:0]);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_second_word", out_instr, mb[31:0]);
    chk("bp_ready_reopen", 32'(in_ready), 32'd1);
    @(posedge clk); #1; in_valid = 1'b0;
    chk("bp_third_word", out_instr, mc[31:0]);
    @(posedge clk); #1 chk("bp_empty", 32'(out_valid), 32'd0);

    // Reset mid-stream discards queued words immediately.
    @(negedge clk); out_ready = 1'b0; apply(ra); in_valid = 1'b1;
    @(posedge clk); @(negedge clk); apply(rb);
    @(posedge clk); #1; in_valid = 1'b0;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_instr", out_instr, 32'h0);
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 chk("post_rst_no_stale", 32'(out_valid), 32'd0);
    exp_cnt = 0;
    q.delete();

    // Randomized traffic against the queue model.
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      chk("rnd_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("rnd_ready", 32'(in_ready), 32'(q.size() < DEPTH));
      chk("rnd_err_count", 32'(err_count), 32'(exp_cnt));
      if (q.size() != 0) begin
        chk("rnd_instr", out_instr, q[0][31:0]);
        chk("rnd_err", 32'(out_err), 32'(q[0][32]));
      end
      rr.t = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: rr.imm = $urandom;
        1: rr.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        2: rr.imm = $urandom & 32'hFFFFF800;
        default: rr.imm = 32'($urandom_range(0, 40));
      endcase
      rr.op = 7'($urandom); rr.f3 = 3'($urandom); rr.f7 = 7'($urandom);
      rr.rd = 5'($urandom); rr.rs1 = 5'($urandom); rr.rs2 = 5'($urandom);
      apply(rr);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      err_clr   = ($urandom_range(0, 31) == 0);
      mr  = model(rr);
      acc = in_valid && (q.size() < DEPTH);
      pp  = out_ready && (q.size() != 0);
      @(posedge clk);
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(mr);
      if (err_clr) exp_cnt = (acc && mr[32]) ? 1 : 0;
      else if (acc && mr[32] && exp_cnt < ERR_MAX) exp_cnt++;
    end
    @(negedge clk); in_valid = 1'b0; err_clr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
